// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the MIPS core.
// Moore FSM that walks each instruction through fetch, decode, execute,
// memory and write-back, driving the shared ALU, unified memory port,
// IR/PC loads and register-file write enables.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCondEQ,
   output logic       PCWriteCondNE,
   output logic [1:0] PCSource,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ExtZero,
   output logic [2:0] ALUOp,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [3:0] StFetch   = 4'd0;
   localparam logic [3:0] StDecode  = 4'd1;
   localparam logic [3:0] StMemAddr = 4'd2;
   localparam logic [3:0] StMemRd   = 4'd3;
   localparam logic [3:0] StMemWb   = 4'd4;
   localparam logic [3:0] StMemWr   = 4'd5;
   localparam logic [3:0] StExecR   = 4'd6;
   localparam logic [3:0] StRWb     = 4'd7;
   localparam logic [3:0] StExecI   = 4'd8;
   localparam logic [3:0] StIWb     = 4'd9;
   localparam logic [3:0] StBranch  = 4'd10;
   localparam logic [3:0] StJump    = 4'd11;
   localparam logic [3:0] StTrap    = 4'd12;

   localparam logic [5:0] OpR    = 6'h00;
   localparam logic [5:0] OpJ    = 6'h02;
   localparam logic [5:0] OpBeq  = 6'h04;
   localparam logic [5:0] OpBne  = 6'h05;
   localparam logic [5:0] OpAddi = 6'h08;
   localparam logic [5:0] OpAndi = 6'h0C;
   localparam logic [5:0] OpOri  = 6'h0D;
   localparam logic [5:0] OpLw   = 6'h23;
   localparam logic [5:0] OpSw   = 6'h2B;

   logic [3:0] stateQ, stateD;
   logic [5:0] opQ;

   assign state = stateQ;

   // State register and opcode capture; opcode is latched on leaving DECODE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= StFetch;
         opQ    <= 6'h00;
      end else begin
         stateQ <= stateD;
         if (stateQ == StDecode) opQ <= OP;
      end
   end

   // Next-state selection; DECODE looks at OP directly, later states at opQ.
   always_comb begin
      stateD = StFetch;
      case (stateQ)
         StFetch:   stateD = mem_ready ? StDecode : StFetch;
         StDecode: begin
            case (OP)
               OpLw, OpSw:           stateD = StMemAddr;
               OpR:                  stateD = StExecR;
               OpAddi, OpAndi, OpOri: stateD = StExecI;
               OpBeq, OpBne:         stateD = StBranch;
               OpJ:                  stateD = StJump;
               default:              stateD = StTrap;
            endcase
         end
         StMemAddr: stateD = (opQ == OpSw) ? StMemWr : StMemRd;
         StMemRd:   stateD = mem_ready ? StMemWb : StMemRd;
         StMemWr:   stateD = mem_ready ? StFetch : StMemWr;
         StExecR:   stateD = StRWb;
         StExecI:   stateD = StIWb;
         default:   stateD = StFetch;
      endcase
   end

   // Moore outputs; mem_ready only qualifies FETCH, MEM_RD and MEM_WR.
   always_comb begin
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      PCSource      = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ExtZero       = 1'b0;
      ALUOp         = 3'b000;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      case (stateQ)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            // No IR/PC load while reset is held, even if memory reports ready.
            IRWrite = mem_ready & reset;
            PCWrite = mem_ready & reset;
         end
         StDecode:  ALUSrcB = 2'b11;
         StMemAddr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StMemRd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         StMemWb: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         StMemWr: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         StExecR: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b111;
         end
         StRWb: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         StExecI: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtZero = (opQ == OpAndi) || (opQ == OpOri);
            case (opQ)
               OpAndi:  ALUOp = 3'b110;
               OpOri:   ALUOp = 3'b101;
               default: ALUOp = 3'b100;
            endcase
         end
         StIWb: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         StBranch: begin
            ALUSrcA       = 1'b1;
            ALUOp         = 3'b001;
            PCSource      = 2'b01;
            PCWriteCondEQ = (opQ == OpBeq);
            PCWriteCondNE = (opQ == OpBne);
            instr_done    = 1'b1;
         end
         StJump: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
         end
         StTrap: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-scenario tasks with
// hand-computed state sequences and strobe values.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OP;
   logic       mem_ready;
   logic       IorD, MemRead, MemWrite, IRWrite, PCWrite;
   logic       PCWriteCondEQ, PCWriteCondNE;
   logic [1:0] PCSource;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       ExtZero;
   logic [2:0] ALUOp;
   logic       RegDst, MemtoReg, RegWrite, instr_done, illegal_op;
   logic [3:0] state;

   int checks = 0;
   int passed = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero),
      .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b0; OP = 6'h00; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      checks++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
      checks++; if (MemRead !== 1'b1) $display("FAIL reset_memread got %b want 1", MemRead); else passed++;
      checks++; if (ALUSrcB !== 2'b01) $display("FAIL reset_alusrcb got %b want 01", ALUSrcB); else passed++;
      checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0)
         $display("FAIL reset_irpc got %b%b want 00", IRWrite, PCWrite); else passed++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_addi();
      int expS [0:3] = '{0, 1, 8, 9};
      int doneCnt = 0;
      OP = 6'h08; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL addi_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         if (expS[i] == 8) begin
            checks++; if (ALUOp !== 3'b100) $display("FAIL addi_aluop got %b want 100", ALUOp); else passed++;
            checks++; if (ExtZero !== 1'b0 || ALUSrcB !== 2'b10)
               $display("FAIL addi_ext got %b/%b want 0/10", ExtZero, ALUSrcB); else passed++;
         end
         checks++; if (RegWrite !== (expS[i] == 9)) $display("FAIL addi_regwrite%0d got %b want %b", i, RegWrite, expS[i] == 9); else passed++;
         if (expS[i] == 9) begin
            checks++; if (RegDst !== 1'b0 || MemtoReg !== 1'b0)
               $display("FAIL addi_wbsel got %b%b want 00", RegDst, MemtoReg); else passed++;
         end
         if (instr_done === 1'b1) doneCnt++;
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0) $display("FAIL addi_end got %0d want 0", state); else passed++;
      checks++; if (doneCnt !== 1) $display("FAIL addi_done got %0d want 1", doneCnt); else passed++;
   endtask

   task automatic test_lw_wait();
      int expS [0:6] = '{0, 1, 2, 3, 3, 3, 4};
      logic rdy [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      OP = 6'h23;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i];
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL lw_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         if (expS[i] == 3) begin
            checks++; if (IorD !== 1'b1 || MemRead !== 1'b1)
               $display("FAIL lw_memrd%0d got %b%b want 11", i, IorD, MemRead); else passed++;
         end
         if (expS[i] == 4) begin
            checks++; if (MemtoReg !== 1'b1 || RegWrite !== 1'b1 || instr_done !== 1'b1)
               $display("FAIL lw_wb got %b%b%b want 111", MemtoReg, RegWrite, instr_done); else passed++;
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0) $display("FAIL lw_end got %0d want 0", state); else passed++;
   endtask

   task automatic test_branch(input logic [5:0] op, input logic isNe);
      int expS [0:2] = '{0, 1, 10};
      OP = op; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL br_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         checks++; if (PCWrite !== (i == 0)) $display("FAIL br_pcwrite%0d got %b want %b", i, PCWrite, i == 0); else passed++;
         if (expS[i] == 10) begin
            checks++; if (PCWriteCondNE !== isNe || PCWriteCondEQ !== !isNe)
               $display("FAIL br_cond got eq=%b ne=%b want eq=%b ne=%b", PCWriteCondEQ, PCWriteCondNE, !isNe, isNe);
            else passed++;
            checks++; if (ALUOp !== 3'b001 || PCSource !== 2'b01 || ALUSrcA !== 1'b1)
               $display("FAIL br_alu got op=%b src=%b a=%b want 001/01/1", ALUOp, PCSource, ALUSrcA); else passed++;
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0) $display("FAIL br_end got %0d want 0", state); else passed++;
   endtask

   task automatic test_illegal();
      int expS [0:2] = '{0, 1, 12};
      int illCnt = 0;
      OP = 6'h3F; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL ill_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         checks++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0)
            $display("FAIL ill_writes%0d got %b%b want 00", i, RegWrite, MemWrite); else passed++;
         if (illegal_op === 1'b1) illCnt++;
         @(negedge clk);
      end
      #1;
      checks++; if (illCnt !== 1) $display("FAIL ill_pulse got %0d want 1", illCnt); else passed++;
      checks++; if (state !== 4'd0 || illegal_op !== 1'b0)
         $display("FAIL ill_end got %0d/%b want 0/0", state, illegal_op); else passed++;
   endtask

   task automatic test_sw_abort();
      int expS [0:6] = '{0, 1, 6, 7, 0, 0, 0};
      OP = 6'h2B; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++; if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || instr_done !== 1'b0)
         $display("FAIL sw_memwr got s=%0d w=%b i=%b d=%b want 5/1/1/0", state, MemWrite, IorD, instr_done);
      else passed++;
      #1 reset = 1'b0;
      #1;
      checks++; if (state !== 4'd0 || MemWrite !== 1'b0)
         $display("FAIL sw_abort got s=%0d w=%b want 0/0", state, MemWrite); else passed++;
      @(negedge clk);
      #1;
      checks++; if (state !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0)
         $display("FAIL sw_held got s=%0d w=%b r=%b want 0/0/0", state, MemWrite, RegWrite); else passed++;
      @(negedge clk);
      reset = 1'b1; OP = 6'h00; mem_ready = 1'b1;
      // Recovery runs a full R-type instruction from FETCH.
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL rec_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         if (expS[i] == 6) begin
            checks++; if (ALUOp !== 3'b111 || ALUSrcB !== 2'b00)
               $display("FAIL r_exec got %b/%b want 111/00", ALUOp, ALUSrcB); else passed++;
         end
         if (expS[i] == 7) begin
            checks++; if (RegDst !== 1'b1 || RegWrite !== 1'b1 || instr_done !== 1'b1)
               $display("FAIL r_wb got %b%b%b want 111", RegDst, RegWrite, instr_done); else passed++;
         end
         if (i < 4) @(negedge clk);
      end
   endtask

   task automatic test_fetch_wait();
      logic rdy [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int expS [0:2] = '{1, 8, 9};
      OP = 6'h0D;
      for (int i = 0; i < 4; i++) begin
         mem_ready = rdy[i];
         #1;
         checks++; if (state !== 4'd0) $display("FAIL fw_state%0d got %0d want 0", i, state); else passed++;
         checks++; if (IRWrite !== rdy[i] || PCWrite !== rdy[i])
            $display("FAIL fw_irpc%0d got %b%b want %b%b", i, IRWrite, PCWrite, rdy[i], rdy[i]); else passed++;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      // ORI continues; mem_ready must not matter outside FETCH/MEM states.
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL ori_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         if (expS[i] == 8) begin
            checks++; if (ALUOp !== 3'b101 || ExtZero !== 1'b1)
               $display("FAIL ori_exec got %b/%b want 101/1", ALUOp, ExtZero); else passed++;
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0) $display("FAIL ori_end got %0d want 0", state); else passed++;
   endtask

   task automatic test_jump();
      int expS [0:2] = '{0, 1, 11};
      OP = 6'h02; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (state !== 4'(expS[i])) $display("FAIL j_state%0d got %0d want %0d", i, state, expS[i]); else passed++;
         if (expS[i] == 11) begin
            checks++; if (PCWrite !== 1'b1 || PCSource !== 2'b10 || instr_done !== 1'b1)
               $display("FAIL j_out got %b/%b/%b want 1/10/1", PCWrite, PCSource, instr_done); else passed++;
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd0) $display("FAIL j_end got %0d want 0", state); else passed++;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw_wait();
      test_branch(6'h05, 1'b1);
      test_branch(6'h04, 1'b0);
      test_illegal();
      test_sw_abort();
      test_fetch_wait();
      test_jump();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
